// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing dpram port A between a CPU (requester 0) and an
// I/O/DMA engine (requester 1). Each access is grant, RAM cycle, then ack.
module dpram_port_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_out,
    output logic          busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0] state;
    logic       sel;
    logic       last;
    logic       elig0;
    logic       elig1;
    logic       win;

    // NOTE: every signal gets a value before any branch, so no latch is inferred.
    always_comb begin
        elig0 = req0 & ~ack0;
        elig1 = req1 & ~ack1;
        win   = 1'b0;
        if (elig0 && elig1) begin
            win = ~last;
        end else if (elig1) begin
            win = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        sel       <= win;
                        mem_addr  <= win ? addr1  : addr0;
                        mem_wdata <= win ? wdata1 : wdata0;
                        mem_en    <= win ? we1    : we0;
                        if (elig0 && elig1) begin
                            last <= win;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM samples mem_* on this edge; address and data stay put.
                    mem_en <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    if (sel) begin
                        rdata1 <= mem_out;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= mem_out;
                        ack0   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Two-requester round-robin arbiter that shares port A of the 1024x16 `dpram` between a CPU data path (requester 0) and an I/O/DMA engine (requester 1). Each requester runs a req/ack handshake. The arbiter registers the winning request onto the RAM port, waits one RAM cycle, then returns read data with a one-cycle ack pulse. Port B of the `dpram` is not touched by this block.

## Interface
- AW, 10, address width (RAM depth 2^AW)
- DW, 16, data width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1 each  access request; held high with stable operands until the matching ack
- we0, we1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  AW each  word address
- wdata0, wdata1  in  DW each  write data
- ack0, ack1  out  1 each  one-cycle completion pulse, registered
- rdata0, rdata1  out  DW each  RAM word at the address after the access; holds until the next ack to that requester
- mem_en  out  1  write enable to `dpram` en_A, registered
- mem_addr  out  AW  to `dpram` addr_A, registered
- mem_wdata  out  DW  to `dpram` data_A, registered
- mem_out  in  DW  from `dpram` out_A; updated on the clock edge that samples addr_A (write-first)
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - Eligible requester: req_i=1 and ack_i=0. An ack-high requester is masked for that cycle.
  - None eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the one not equal to `last`, then set `last` to the winner.
  - On grant: register mem_addr←addr_i, mem_wdata←wdata_i, mem_en←we_i, sel←i; next state ACCESS.
- **ACCESS**
  - The RAM samples mem_* on this edge.
  - Arbiter clears mem_en; mem_addr and mem_wdata hold their values.
  - Next state RESP.
- **RESP**
  - Capture rdata_sel←mem_out and pulse ack_sel=1 for one cycle.
  - Next state IDLE.
  - Writes also return the word just written in rdata.
- Requesters drop req in the cycle ack is high, or change operands for a new request. A req still high after the ack cycle is treated as a new request.
- Requester operands are sampled only at grant; changes after grant are ignored.
- mem_en is high for exactly one cycle per write grant and never high on reads.

## Timing
- Reset (asynchronous, immediate): state=IDLE, mem_en=0, mem_addr=0, mem_wdata=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, last=1 (requester 0 wins the first tie).
- Latency:
  - req sampled at edge E0, mem_* valid after E0.
  - RAM access at E1.
  - ack and rdata valid after E2.
  - ack is 3 edges after the request.
- Throughput: one access per 3 cycles. The next grant earliest at E3.
- Back-to-back contention: with req0 and req1 both held, grants alternate 0,1,0,1.
- Reset mid-operation:
  - Asserted in ACCESS before E1: mem_en forced low, so no write reaches the RAM.
  - Asserted after E1: the write has already completed.
  - In both cases no ack is issued and the requester must re-request.
- Address wrap: addresses are AW-bit unsigned with no arithmetic; 1023 is valid.

## Test plan
- Single write then read, requester 0: write 0xBEEF to 0x3FF, ack0 after 3 edges; read 0x3FF returns rdata0=0xBEEF, mem_en high exactly one cycle for the write only.
- Simultaneous first requests after reset: req0 writes 0x1111@5, req1 writes 0x2222@6. ack0 comes first, ack1 three cycles later; reads of 5 and 6 return 0x1111 and 0x2222.
- Held contention for 12 cycles: ack order 0,1,0,1, each ack pulse 1 cycle wide, rdata of the other requester unchanged.
- Ack masking: requester holds req until ack and then drops it. Exactly one access per request, with no duplicate mem_en pulse.
- Reset during ACCESS of a write 0xAAAA@0x10: mem_en low immediately, all outputs at reset values, no ack; a later read of 0x10 returns its prior value.
- Random 160 mixed accesses from both requesters against a reference memory model: every ack'd read matches the model, and `busy` is low only in IDLE.
